ftq_meta_rd_sched: RTL

//  Read-port scheduler for the FTQ meta SRAM wrapper (8 sets x 256b, one read port, one write port).

---
 rtl/ftq_meta_rd_sched.sv | 80 ++++++++
 1 files changed

// File: rtl/ftq_meta_rd_sched.sv
// ftq_meta_rd_sched: two-requester read scheduler for the FTQ meta SRAM; FTQ_META_RD_BYPASS_EN forwards same-set writes
module ftq_meta_rd_sched #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 256,
  parameter int STARVE_N = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_r_valid,
  output logic              io_r_ready,
  input  logic [ADDR_W-1:0] io_r_addr,
  input  logic              io_c_valid,
  output logic              io_c_ready,
  input  logic [ADDR_W-1:0] io_c_addr,
  input  logic              io_wen,
  input  logic [ADDR_W-1:0] io_waddr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_resp_valid,
  output logic              io_resp_src,
  output logic [DATA_W-1:0] io_resp_data,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [DATA_W-1:0] sram_wdata
);
  logic [3:0] starve_cnt;
  logic r_blk, c_blk, r_ok, c_ok, force_c, r_acc, c_acc;
`ifdef FTQ_META_RD_BYPASS_EN
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
  assign r_blk = 1'b0;
  assign c_blk = 1'b0;
`else
  // a same-set write this cycle would make the SRAM return stale data next cycle
  assign r_blk = io_wen && io_waddr == io_r_addr;
  assign c_blk = io_wen && io_waddr == io_c_addr;
`endif
  always_comb begin
    force_c    = starve_cnt == 4'(STARVE_N);
    r_ok       = io_r_valid && !r_blk;
    c_ok       = io_c_valid && !c_blk;
    io_r_ready = !r_blk && !(force_c && c_ok);
    io_c_ready = !c_blk && (force_c || !r_ok);
    r_acc      = io_r_valid && io_r_ready;
    c_acc      = io_c_valid && io_c_ready;
    sram_ren   = r_acc || c_acc;
    sram_raddr = c_acc ? io_c_addr : io_r_addr;
    sram_wen   = io_wen;
    sram_waddr = io_waddr;
    sram_wdata = io_wdata;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt    <= '0;
      io_resp_valid <= 1'b0;
      io_resp_src   <= 1'b0;
    end else begin
      io_resp_valid <= sram_ren;
      io_resp_src   <= c_acc;
      starve_cnt    <= c_acc ? 4'd0 :
                       (io_c_valid && !force_c) ? starve_cnt + 4'd1 : starve_cnt;
    end
  end
`ifdef FTQ_META_RD_BYPASS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit  <= sram_ren && io_wen && io_waddr == sram_raddr;
      byp_data <= io_wdata;
    end
  end
  assign io_resp_data = byp_hit ? byp_data : sram_rdata;
`else
  assign io_resp_data = sram_rdata;
`endif
endmodule
